// File: rtl/sbox_bram_pkg.sv
// Shared widths and latency for the masked S-box table BRAM controller.
// The BRAM address is the segment selector concatenated above one share.
package sbox_bram_pkg;
  localparam int SBOX_DATA_W = 8;
  localparam int SBOX_SEL_W  = 2;
  localparam int SBOX_ADDR_W = SBOX_SEL_W + SBOX_DATA_W;
  localparam int SBOX_RD_LAT = 2;
  localparam int SBOX_TAG_W  = 4;
endpackage

// File: rtl/sbox_lat_pipe.sv
// Enable-gated valid+tag shift register tracking reads in flight through the BRAM.
// It freezes together with the BRAM so each tag stays aligned with its read data.
module sbox_lat_pipe #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_v,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_v,
  output logic [TAG_W-1:0] out_tag
);
  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][TAG_W-1:0] tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      tag <= '0;
    end else if (en) begin
      v[0]   <= in_v;
      tag[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        v[i]   <= v[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign out_v   = v[DEPTH-1];
  assign out_tag = tag[DEPTH-1];
endmodule

// File: rtl/masked_sbox_bram_ctrl.sv
// Drives a dual-port masked S-box table BRAM from a share pair and returns
// the two table outputs with their tag through a valid/ready stream.
module masked_sbox_bram_ctrl
  import sbox_bram_pkg::*;
#(
  parameter int DATA_W = SBOX_DATA_W,
  parameter int SEL_W  = SBOX_SEL_W,
  parameter int TAG_W  = SBOX_TAG_W,
  parameter int RD_LAT = SBOX_RD_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [DATA_W-1:0]       in_x0,
  input  logic [DATA_W-1:0]       in_x1,
  input  logic [TAG_W-1:0]        in_tag,
  output logic [SEL_W+DATA_W-1:0] bram_addra,
  output logic [SEL_W+DATA_W-1:0] bram_addrb,
  output logic                    bram_en,
  input  logic [DATA_W-1:0]       bram_doa,
  input  logic [DATA_W-1:0]       bram_dob,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_y0,
  output logic [DATA_W-1:0]       out_y1,
  output logic [TAG_W-1:0]        out_tag
);
  logic             pipe_v;
  logic [TAG_W-1:0] pipe_tag;
  logic             stall;
  logic             accept;

  assign bram_addra = {in_sel, in_x0};
  assign bram_addrb = {in_sel, in_x1};

  // Only stall when a finished read would overwrite an unconsumed result.
  // The BRAM stays enabled through reset so its output registers clear.
  assign stall    = pipe_v && out_valid && !out_ready;
  assign bram_en  = rst || !stall;
  assign in_ready = !stall && !rst;
  assign accept   = in_valid && in_ready;

  sbox_lat_pipe #(
    .TAG_W (TAG_W),
    .DEPTH (RD_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .en      (bram_en),
    .in_v    (accept),
    .in_tag  (in_tag),
    .out_v   (pipe_v),
    .out_tag (pipe_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y0    <= '0;
      out_y1    <= '0;
      out_tag   <= '0;
    end else if (bram_en) begin
      if (pipe_v) begin
        out_valid <= 1'b1;
        out_y0    <= bram_doa;
        out_y1    <= bram_dob;
        out_tag   <= pipe_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_masked_sbox_bram_ctrl.sv
// Bench for masked_sbox_bram_ctrl: behavioural dual-port BRAM, table-lookup
// scoreboard checked every cycle, plus directed literal expectations.
module tb_masked_sbox_bram_ctrl;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sel;
  logic [7:0] in_x0;
  logic [7:0] in_x1;
  logic [3:0] in_tag;
  logic [9:0] bram_addra;
  logic [9:0] bram_addrb;
  logic       bram_en;
  logic [7:0] bram_doa;
  logic [7:0] bram_dob;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y0;
  logic [7:0] out_y1;
  logic [3:0] out_tag;

  masked_sbox_bram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_x0      (in_x0),
    .in_x1      (in_x1),
    .in_tag     (in_tag),
    .bram_addra (bram_addra),
    .bram_addrb (bram_addrb),
    .bram_en    (bram_en),
    .bram_doa   (bram_doa),
    .bram_dob   (bram_dob),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y0     (out_y0),
    .out_y1     (out_y1),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural table BRAM: latch + output register, both EN-qualified, sync reset to 0.
  logic [7:0] mem [0:1023];
  logic [7:0] lat_a, lat_b;
  always @(posedge clk) begin
    if (rst) begin
      lat_a    <= 8'h00;
      lat_b    <= 8'h00;
      bram_doa <= 8'h00;
      bram_dob <= 8'h00;
    end else if (bram_en) begin
      lat_a    <= mem[bram_addra];
      lat_b    <= mem[bram_addrb];
      bram_doa <= lat_a;
      bram_dob <= lat_b;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted request must come out once, in order, as table lookups.
  logic [19:0] exp_q[$];
  logic [19:0] exp_e;
  int          hs_cnt   = 0;
  int          run      = 0;
  int          last_run = 0;
  logic        prev_rst  = 1'b0;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_y0, prev_y1;
  logic [3:0]  prev_tag;

  always @(negedge clk) begin
    chk("addra", {22'd0, bram_addra}, {22'd0, in_sel, in_x0});
    chk("addrb", {22'd0, bram_addrb}, {22'd0, in_sel, in_x1});
    if (rst) begin
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_bram_en", {31'd0, bram_en}, 32'd1);
      exp_q.delete();
    end else begin
      chk("en_eq_ready", {31'd0, bram_en}, {31'd0, in_ready});
      if (prev_rst) begin
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_y0", {24'd0, out_y0}, 32'd0);
        chk("post_rst_y1", {24'd0, out_y1}, 32'd0);
        chk("post_rst_tag", {28'd0, out_tag}, 32'd0);
      end
      if (prev_hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_y0", {24'd0, out_y0}, {24'd0, prev_y0});
        chk("hold_y1", {24'd0, out_y1}, {24'd0, prev_y1});
        chk("hold_tag", {28'd0, out_tag}, {28'd0, prev_tag});
      end
      if (out_valid === 1'b1)
        chk("no_spurious_out", {31'd0, exp_q.size() != 0}, 32'd1);
      if (out_valid === 1'b1 && out_ready && exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        chk("out_y0", {24'd0, out_y0}, {24'd0, exp_e[19:12]});
        chk("out_y1", {24'd0, out_y1}, {24'd0, exp_e[11:4]});
        chk("out_tag", {28'd0, out_tag}, {28'd0, exp_e[3:0]});
        hs_cnt++;
      end
      if (in_valid && in_ready === 1'b1)
        exp_q.push_back({mem[{in_sel, in_x0}], mem[{in_sel, in_x1}], in_tag});
    end
    if (out_valid === 1'b1 && !rst) begin
      run++;
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    prev_rst  = rst;
    prev_hold = (out_valid === 1'b1) && !out_ready && !rst;
    prev_y0   = out_y0;
    prev_y1   = out_y1;
    prev_tag  = out_tag;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted (bounded); returns just after the accepting edge.
  task automatic send(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] t);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_sel   = s;
    in_x0    = a;
    in_x1    = b;
    in_tag   = t;
    n        = 0;
    acc      = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  int         lat;
  int         hs0;
  int         i;
  int         c;
  logic       acc;
  logic [3:0] held_tag;

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 8'((k * 29 + 7 * (k >> 8)) ^ (k >> 3));
    mem[10'h000] = 8'h00;
    mem[10'h01F] = 8'hAC;
    mem[10'h100] = 8'hF7;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_x0     = 8'h00;
    in_x1     = 8'h00;
    in_tag    = 4'h0;
    out_ready = 1'b1;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("t1_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_y0", {24'd0, out_y0}, 32'h00);
    chk("t1_y1", {24'd0, out_y1}, 32'h00);
    chk("t1_tag", {28'd0, out_tag}, 32'd0);
    chk("t1_en", {31'd0, bram_en}, 32'd1);
    chk("t1_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    step();

    // Single read
    in_sel = 2'd0; in_x0 = 8'h00; in_x1 = 8'h1F;
    #1;
    chk("t2_addra", {22'd0, bram_addra}, 32'h000);
    chk("t2_addrb", {22'd0, bram_addrb}, 32'h01F);
    send(2'd0, 8'h00, 8'h1F, 4'h5);
    wait_valid(lat);
    chk("t2_latency", lat, 32'd3);
    chk("t2_y0", {24'd0, out_y0}, 32'h00);
    chk("t2_y1", {24'd0, out_y1}, 32'hAC);
    chk("t2_tag", {28'd0, out_tag}, 32'h5);
    repeat (3) step();

    // Segment select
    in_sel = 2'b01; in_x0 = 8'h00; in_x1 = 8'h00;
    #1;
    chk("t3_addra", {22'd0, bram_addra}, 32'h100);
    chk("t3_addrb", {22'd0, bram_addrb}, 32'h100);
    send(2'b01, 8'h00, 8'h00, 4'h3);
    wait_valid(lat);
    chk("t3_latency", lat, 32'd3);
    chk("t3_y0", {24'd0, out_y0}, 32'hF7);
    chk("t3_y1", {24'd0, out_y1}, 32'hF7);
    repeat (3) step();

    // Back-to-back, 16 requests
    hs0 = hs_cnt;
    for (int k = 0; k < 16; k++) send(2'd0, 8'(k), 8'(255 - k), 4'(k));
    repeat (8) step();
    chk("t4_run_len", last_run, 32'd16);
    chk("t4_count", hs_cnt - hs0, 32'd16);

    // Backpressure: out_ready low for 5 cycles mid-stream
    hs0 = hs_cnt;
    i = 0;
    c = 0;
    held_tag = 4'h0;
    while (i < 8 && c < 60) begin
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      in_x0     = 8'(8'h40 + i);
      in_x1     = 8'(8'h80 + i);
      in_tag    = 4'(i);
      out_ready = !(c >= 4 && c <= 8);
      @(negedge clk);
      acc = in_ready;
      if (c >= 4 && c <= 8) begin
        chk("t5_stall_ready", {31'd0, in_ready}, 32'd0);
        chk("t5_stall_en", {31'd0, bram_en}, 32'd0);
        chk("t5_stall_valid", {31'd0, out_valid}, 32'd1);
      end
      if (c == 4) held_tag = out_tag;
      if (c == 8) chk("t5_held_tag", {28'd0, out_tag}, {28'd0, held_tag});
      step();
      if (acc) i++;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t5_all_sent", i, 32'd8);
    repeat (10) step();
    chk("t5_delivered", hs_cnt - hs0, 32'd8);
    chk("t5_queue_empty", exp_q.size(), 32'd0);

    // Reset with two reads in flight
    send(2'd3, 8'h11, 8'h22, 4'h8);
    send(2'd3, 8'h33, 8'h44, 4'h9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid_after_rst", {31'd0, out_valid}, 32'd0);
    hs0 = hs_cnt;
    repeat (5) step();
    chk("t6_no_ghost", hs_cnt - hs0, 32'd0);
    send(2'd0, 8'h1F, 8'h00, 4'hC);
    wait_valid(lat);
    chk("t6_latency", lat, 32'd3);
    chk("t6_tag", {28'd0, out_tag}, 32'hC);
    chk("t6_y0", {24'd0, out_y0}, 32'hAC);
    chk("t6_y1", {24'd0, out_y1}, 32'h00);
    repeat (3) step();
    chk("t6_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
